pong_match_fsm: RTL and testbench

Parametrised match controller for the Pong design. It owns the game state (idle, serve, play, pause, game over), the per-player BCD scores and the win decision. It sits between the debounced start button and the asset/ball logic, and replaces the ad-hoc run toggle in the top level. It generalises that toggle to N players, a configurable winning score, pause and a timed serve.

---
 rtl/pong_pkg.sv | 43 ++++
 rtl/bcd_score_counter.sv | 27 ++
 rtl/pong_match_fsm.sv | 158 +++++++++++++++
 tb/tb_pong_match_fsm.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// pong_pkg: match-state encoding and BCD helpers shared by the Pong match controller.
// Rev 1.0
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } match_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    function automatic logic [7:0] bin_to_bcd(input int unsigned value);
        int unsigned tens;
        int unsigned ones;
        tens = (value / 10) % 10;
        ones = value % 10;
        return {tens[3:0], ones[3:0]};
    endfunction

    // Saturates at 99 so a mis-set win score can never wrap the display.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        bcd_digit_t tens;
        bcd_digit_t ones;
        tens = value[7:4];
        ones = value[3:0];
        if (value == BCD_MAX) begin
            return BCD_MAX;
        end
        if (ones == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// bcd_score_counter: two-digit BCD score register with synchronous clear and increment.
// Rev 1.0
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       inc_i,
    output logic [7:0] score_o
);

    logic [7:0] score_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            score_q <= 8'h00;
        end else if (inc_i) begin
            score_q <= bcd_inc(score_q);
        end
    end

    assign score_o = score_q;

endmodule
`default_nettype wire

// File: rtl/pong_match_fsm.sv
`default_nettype none
// pong_match_fsm: N-player Pong match controller (serve timing, pause, BCD scores, win decision).
// Rev 1.0
module pong_match_fsm
    import pong_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_TICKS = 60,
    parameter int PW          = $clog2(NUM_PLAYERS)
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     tick,
    input  logic                     start_btn,
    input  logic [NUM_PLAYERS-1:0]   point,
    output logic                     running,
    output logic                     ball_reset,
    output logic [PW-1:0]            serve_player,
    output logic [8*NUM_PLAYERS-1:0] score_bcd,
    output logic                     game_over,
    output logic [PW-1:0]            winner
);

    localparam logic [7:0] WIN_BCD    = bin_to_bcd(WIN_SCORE);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS);

    match_state_e  state_q;
    match_state_e  ret_q;
    logic          start_q;
    logic          edge_q;
    logic [7:0]    serve_cnt_q;
    logic [PW-1:0] scorer_q;
    logic          running_q;
    logic          ball_reset_q;
    logic [PW-1:0] serve_player_q;
    logic          game_over_q;
    logic [PW-1:0] winner_q;

    logic [PW-1:0] first_idx;
    logic          any_point;
    logic          score_clr;
    logic          won;
    logic [7:0]    scores [NUM_PLAYERS];

    // Lowest index wins when several players score in the same cycle.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (point[i]) begin
                first_idx = PW'(i);
            end
        end
    end

    assign any_point = |point;
    assign score_clr = edge_q && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    assign won       = (bcd_inc(scores[scorer_q]) == WIN_BCD);

    generate
        for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
            bcd_score_counter u_score (
                .clk     (clk),
                .rst     (clr),
                .clear_i (score_clr),
                .inc_i   ((state_q == ST_POINT) && (scorer_q == PW'(g))),
                .score_o (scores[g])
            );
            assign score_bcd[8*g +: 8] = scores[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        // The level copy keeps tracking through reset so a held button never fakes an edge.
        start_q <= start_btn;
        if (clr) begin
            state_q        <= ST_IDLE;
            ret_q          <= ST_PLAY;
            edge_q         <= 1'b0;
            serve_cnt_q    <= 8'd0;
            scorer_q       <= '0;
            running_q      <= 1'b0;
            ball_reset_q   <= 1'b0;
            serve_player_q <= '0;
            game_over_q    <= 1'b0;
            winner_q       <= '0;
        end else begin
            edge_q       <= start_btn && !start_q;
            ball_reset_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (edge_q) begin
                        state_q      <= ST_SERVE;
                        ball_reset_q <= 1'b1;
                        serve_cnt_q  <= SERVE_LOAD;
                        game_over_q  <= 1'b0;
                        running_q    <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (edge_q) begin
                        state_q <= ST_PAUSE;
                        ret_q   <= ST_SERVE;
                    end else if (tick) begin
                        if (serve_cnt_q <= 8'd1) begin
                            serve_cnt_q <= 8'd0;
                            state_q     <= ST_PLAY;
                            running_q   <= 1'b1;
                        end else begin
                            serve_cnt_q <= serve_cnt_q - 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (any_point) begin
                        state_q   <= ST_POINT;
                        scorer_q  <= first_idx;
                        running_q <= 1'b0;
                    end else if (edge_q) begin
                        state_q   <= ST_PAUSE;
                        ret_q     <= ST_PLAY;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (edge_q) begin
                        state_q   <= ret_q;
                        running_q <= (ret_q == ST_PLAY);
                    end
                end
                ST_POINT: begin
                    serve_player_q <= scorer_q;
                    if (won) begin
                        state_q     <= ST_OVER;
                        game_over_q <= 1'b1;
                        winner_q    <= scorer_q;
                    end else begin
                        state_q      <= ST_SERVE;
                        ball_reset_q <= 1'b1;
                        serve_cnt_q  <= SERVE_LOAD;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign running      = running_q;
    assign ball_reset   = ball_reset_q;
    assign serve_player = serve_player_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_fsm.sv
`default_nettype none
// tb_pong_match_fsm: directed stimulus against two configurations with a per-cycle reference model.
// Rev 1.0
module tb_pong_match_fsm;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_POINT = 4;
    localparam int M_OVER  = 5;

    logic       clk       = 1'b0;
    logic       clr       = 1'b1;
    logic       sel       = 1'b0;
    logic       tick      = 1'b0;
    logic       tick_en   = 1'b0;
    logic       start_btn = 1'b0;
    logic [3:0] point     = 4'b0000;
    logic       armed     = 1'b0;
    int         checks    = 0;
    int         failures  = 0;

    logic        clr_a;
    logic        clr_b;
    logic        run_a, br_a, go_a;
    logic [0:0]  sp_a, win_a;
    logic [15:0] sc_a;
    logic        run_b, br_b, go_b;
    logic [1:0]  sp_b, win_b;
    logic [31:0] sc_b;

    // Only the selected configuration is out of reset.
    assign clr_a = clr | sel;
    assign clr_b = clr | ~sel;

    pong_match_fsm #(.NUM_PLAYERS(2), .WIN_SCORE(11), .SERVE_TICKS(60)) u_dut_a (
        .clk(clk), .clr(clr_a), .tick(tick), .start_btn(start_btn), .point(point[1:0]),
        .running(run_a), .ball_reset(br_a), .serve_player(sp_a), .score_bcd(sc_a),
        .game_over(go_a), .winner(win_a)
    );

    pong_match_fsm #(.NUM_PLAYERS(4), .WIN_SCORE(99), .SERVE_TICKS(3)) u_dut_b (
        .clk(clk), .clr(clr_b), .tick(tick), .start_btn(start_btn), .point(point),
        .running(run_b), .ball_reset(br_b), .serve_player(sp_b), .score_bcd(sc_b),
        .game_over(go_b), .winner(win_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick = tick_en && !tick;
        end
    end

    // Reference model: binary scores, mode per match phase, outputs derived from the mode.
    int m_mode   [2];
    int m_resume [2];
    int m_left   [2];
    int m_sc     [2][4];
    int m_scorer [2];
    int m_sp     [2];
    int m_win    [2];
    bit m_br     [2];
    bit m_prev   [2];
    bit m_edge   [2];

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_step(input int d, input bit rst_in, input bit tk, input bit btn,
                              input logic [3:0] pt);
        int np;
        int target;
        int serve;
        int first;
        bit e;
        np     = (d == 0) ? 2 : 4;
        target = (d == 0) ? 11 : 99;
        serve  = (d == 0) ? 60 : 3;
        e         = m_edge[d];
        m_edge[d] = btn && !m_prev[d];
        m_prev[d] = btn;
        m_br[d]   = 1'b0;
        first = -1;
        for (int i = np - 1; i >= 0; i--) begin
            if (pt[i]) first = i;
        end
        if (rst_in) begin
            m_mode[d] = M_IDLE;
            m_edge[d] = 1'b0;
            m_sp[d]   = 0;
            m_win[d]  = 0;
            m_left[d] = 0;
            for (int i = 0; i < 4; i++) m_sc[d][i] = 0;
        end else begin
            case (m_mode[d])
                M_IDLE, M_OVER: if (e) begin
                    for (int i = 0; i < 4; i++) m_sc[d][i] = 0;
                    m_br[d]   = 1'b1;
                    m_left[d] = serve;
                    m_mode[d] = M_SERVE;
                end
                M_SERVE: begin
                    if (e) begin
                        m_resume[d] = M_SERVE;
                        m_mode[d]   = M_PAUSE;
                    end else if (tk) begin
                        m_left[d] = m_left[d] - 1;
                        if (m_left[d] == 0) m_mode[d] = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (first >= 0) begin
                        m_scorer[d] = first;
                        m_mode[d]   = M_POINT;
                    end else if (e) begin
                        m_resume[d] = M_PLAY;
                        m_mode[d]   = M_PAUSE;
                    end
                end
                M_PAUSE: if (e) m_mode[d] = m_resume[d];
                M_POINT: begin
                    m_sc[d][m_scorer[d]] = m_sc[d][m_scorer[d]] + 1;
                    m_sp[d] = m_scorer[d];
                    if (m_sc[d][m_scorer[d]] == target) begin
                        m_mode[d] = M_OVER;
                        m_win[d]  = m_scorer[d];
                    end else begin
                        m_br[d]   = 1'b1;
                        m_left[d] = serve;
                        m_mode[d] = M_SERVE;
                    end
                end
                default: m_mode[d] = M_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_dut(input int d, input logic run, input logic br, input logic go,
                               input logic [1:0] sp, input logic [1:0] win, input logic [31:0] sc);
        int np;
        string tag;
        np  = (d == 0) ? 2 : 4;
        tag = (d == 0) ? "A" : "B";
        chk({tag, ".running"},      32'(run), 32'(m_mode[d] == M_PLAY));
        chk({tag, ".game_over"},    32'(go),  32'(m_mode[d] == M_OVER));
        chk({tag, ".ball_reset"},   32'(br),  32'(m_br[d]));
        chk({tag, ".serve_player"}, 32'(sp),  32'(m_sp[d]));
        for (int i = 0; i < np; i++) begin
            chk($sformatf("%s.score%0d", tag, i), 32'(sc[8*i +: 8]), 32'(to_bcd(m_sc[d][i])));
        end
        if (m_mode[d] == M_OVER) chk({tag, ".winner"}, 32'(win), 32'(m_win[d]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, clr_a, tick, start_btn, {2'b00, point[1:0]});
            model_step(1, clr_b, tick, start_btn, point);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                compare_dut(0, run_a, br_a, go_a, {1'b0, sp_a}, {1'b0, win_a}, {16'h0000, sc_a});
                compare_dut(1, run_b, br_b, go_b, sp_b, win_b, sc_b);
            end
        end
    end

    function automatic logic act_run();
        return sel ? run_b : run_a;
    endfunction

    task automatic wait_running(input int budget);
        int n;
        n = 0;
        while (!act_run() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!act_run()) begin
            checks++;
            failures++;
            $display("FAIL wait_running timeout actual=0 required=1 at %0t", $time);
        end
    endtask

    task automatic press();
        @(negedge clk); start_btn = 1'b1;
        @(negedge clk);
        @(negedge clk); start_btn = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        @(negedge clk); point = v;
        @(negedge clk); point = 4'b0000;
        chk("running_after_point", 32'(act_run()), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("reset_running",      32'(run_a), 32'd0);
        chk("reset_ball_reset",   32'(br_a),  32'd0);
        chk("reset_serve_player", 32'(sp_a),  32'd0);
        chk("reset_scores",       32'(sc_a),  32'd0);
        chk("reset_game_over",    32'(go_a),  32'd0);
        chk("reset_winner",       32'(win_a), 32'd0);
        @(negedge clk);
        clr     = 1'b0;
        tick_en = 1'b1;

        // Match to win: player 1 takes all eleven points.
        press();
        chk("start_ball_reset", 32'(br_a), 32'd1);
        for (int k = 1; k <= 11; k++) begin
            wait_running(400);
            pulse(4'b0010);
            @(negedge clk);
            if (k < 11) chk("serve_ball_reset", 32'(br_a), 32'd1);
        end
        chk("win_score_p1", 32'(sc_a[15:8]), 32'h11);
        chk("win_score_p0", 32'(sc_a[7:0]),  32'h00);
        chk("win_game_over", 32'(go_a), 32'd1);
        chk("win_winner",    32'(win_a), 32'd1);
        chk("win_no_ball_reset", 32'(br_a), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("over_no_ball_reset", 32'(br_a), 32'd0);
        end

        // Pause during play: points ignored, play resumes two cycles after the edge.
        press();
        chk("restart_game_over", 32'(go_a), 32'd0);
        chk("restart_scores",    32'(sc_a), 32'd0);
        wait_running(400);
        press();
        chk("pause_running", 32'(run_a), 32'd0);
        pulse(4'b0001);
        pulse(4'b0001);
        @(negedge clk);
        chk("pause_scores", 32'(sc_a), 32'd0);
        @(negedge clk); start_btn = 1'b1;
        @(negedge clk);
        chk("resume_not_yet", 32'(run_a), 32'd0);
        @(negedge clk); start_btn = 1'b0;
        chk("resume_running", 32'(run_a), 32'd1);

        // Build a 3/5 score, then reset during the serve with the button held.
        for (int k = 0; k < 8; k++) begin
            wait_running(400);
            pulse((k < 3) ? 4'b0001 : 4'b0010);
            @(negedge clk);
        end
        chk("midmatch_scores", 32'(sc_a), 32'h0503);
        @(negedge clk); clr = 1'b1; start_btn = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("clr_running",    32'(run_a), 32'd0);
        chk("clr_ball_reset", 32'(br_a),  32'd0);
        chk("clr_game_over",  32'(go_a),  32'd0);
        chk("clr_scores",     32'(sc_a),  32'd0);
        repeat (10) begin
            @(negedge clk);
            chk("held_start_idle", 32'(br_a), 32'd0);
        end
        start_btn = 1'b0;
        press();
        chk("fresh_edge_starts", 32'(br_a), 32'd1);

        // Four-player configuration: BCD carry and simultaneous points.
        @(negedge clk); sel = 1'b1;
        press();
        chk("b_start_ball_reset", 32'(br_b), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            wait_running(100);
            pulse(4'b0001);
            @(negedge clk);
            if (k == 9)  chk("b_score_09", 32'(sc_b[7:0]), 32'h09);
            if (k == 10) chk("b_score_10", 32'(sc_b[7:0]), 32'h10);
        end
        wait_running(100);
        pulse(4'b0110);
        @(negedge clk);
        chk("simul_p1",     32'(sc_b[15:8]),  32'h01);
        chk("simul_p2",     32'(sc_b[23:16]), 32'h00);
        chk("simul_p0",     32'(sc_b[7:0]),   32'h10);
        chk("simul_server", 32'(sp_b),        32'd1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
